// File: rtl/bip_report_tx.sv
// Result-reporting serialiser for the BIP core: on a rising edge of i_done, frames the count and accumulator as bytes for a UART TX.
// Optional trailing XOR checksum byte is enabled by defining BIP_REPORT_CHECKSUM_EN.
module bip_report_tx #(
  parameter int         ACC_WIDTH   = 16,
  parameter int         COUNT_WIDTH = 8,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_done,
  input  logic [ACC_WIDTH-1:0]   i_accumulator,
  input  logic [COUNT_WIDTH-1:0] i_inst_count,
  input  logic                   i_tx_done,
  output logic                   o_tx_start,
  output logic [7:0]             o_tx_data,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic                   o_overrun
);

  localparam int N_ACC   = (ACC_WIDTH + 7) / 8;
  localparam int N_CNT   = (COUNT_WIDTH + 7) / 8;
`ifdef BIP_REPORT_CHECKSUM_EN
  localparam int N_CHK   = 1;
`else
  localparam int N_CHK   = 0;
`endif
  localparam int N_BYTES = 1 + N_CNT + N_ACC + N_CHK;
  localparam int IDX_W   = $clog2(N_BYTES + 1);
  localparam int ACC_BW  = 8 * N_ACC;
  localparam int CNT_BW  = 8 * N_CNT;
  localparam int FRAME_W = 8 * N_BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic               done_q;
  logic               trig;
  logic               capture;
  logic [CNT_BW-1:0]  cnt_p0;
  logic [ACC_BW-1:0]  acc_p0;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               vld_p1, vld_d;
  logic [7:0]         tx_data_p1, tx_data_d;
  logic               busy_q, busy_d;
  logic               fdone_q, fdone_d;
  logic               overrun_q, overrun_d;
  logic [FRAME_W-1:0] frame_vec;

  // Byte 0 is the leftmost (header) byte of the flattened frame.
  function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] f,
                                            input logic [IDX_W-1:0]   idx);
    logic [FRAME_W-1:0] sh;
    sh = f >> (8 * (N_BYTES - 1 - int'(idx)));
    return sh[7:0];
  endfunction

`ifdef BIP_REPORT_CHECKSUM_EN
  function automatic logic [7:0] checksum(input logic [CNT_BW-1:0] c,
                                          input logic [ACC_BW-1:0] a);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < N_CNT; i++) x = x ^ c[8*i +: 8];
    for (int i = 0; i < N_ACC; i++) x = x ^ a[8*i +: 8];
    return x;
  endfunction

  assign frame_vec = {HEADER_BYTE, cnt_p0, acc_p0, checksum(cnt_p0, acc_p0)};
`else
  assign frame_vec = {HEADER_BYTE, cnt_p0, acc_p0};
`endif

  assign trig = i_done & ~done_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vld_d     = 1'b0;
    tx_data_d = tx_data_p1;
    busy_d    = busy_q;
    fdone_d   = 1'b0;
    capture   = 1'b0;
    // Any edge outside IDLE (including the DONE cycle) is lost and flagged.
    overrun_d = overrun_q | (trig & (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          capture   = 1'b1;
          idx_d     = '0;
          busy_d    = 1'b1;
          vld_d     = 1'b1;
          tx_data_d = HEADER_BYTE;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) begin
          if (idx_q == LAST_IDX) begin
            fdone_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            idx_d     = idx_q + 1'b1;
            vld_d     = 1'b1;
            tx_data_d = frame_byte(frame_vec, idx_q + 1'b1);
            state_d   = ST_SEND;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture stage: frame fields latched once per accepted trigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
      acc_p0 <= '0;
    end else if (capture) begin
      cnt_p0 <= CNT_BW'(i_inst_count);
      acc_p0 <= ACC_BW'(i_accumulator);
    end
  end

  // Output stage: control and registered byte/valid toward the UART.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      idx_q      <= '0;
      vld_p1     <= 1'b0;
      tx_data_p1 <= '0;
      busy_q     <= 1'b0;
      fdone_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= i_done;
      idx_q      <= idx_d;
      vld_p1     <= vld_d;
      tx_data_p1 <= tx_data_d;
      busy_q     <= busy_d;
      fdone_q    <= fdone_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_tx_start   = vld_p1;
  assign o_tx_data    = tx_data_p1;
  assign o_busy       = busy_q;
  assign o_frame_done = fdone_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_bip_report_tx.sv
// Directed bench for bip_report_tx: default-width instance plus a 12/10-bit instance, each with a UART TX responder.
module tb_bip_report_tx;

  typedef logic [7:0] byteq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        done1, tx_done1, start1, busy1, fdone1, ovr1;
  logic [15:0] acc1;
  logic [7:0]  cnt1, data1;
  logic        done2, tx_done2, start2, busy2, fdone2, ovr2;
  logic [11:0] acc2;
  logic [9:0]  cnt2;
  logic [7:0]  data2;

  int checks = 0, failures = 0;
  int frames1 = 0, frames2 = 0;
  int cd1 = 0, cd2 = 0;
  byteq_t q1, q2;

  bip_report_tx dut (
    .clk(clk), .rst(rst), .i_done(done1), .i_accumulator(acc1), .i_inst_count(cnt1),
    .i_tx_done(tx_done1), .o_tx_start(start1), .o_tx_data(data1), .o_busy(busy1),
    .o_frame_done(fdone1), .o_overrun(ovr1));

  bip_report_tx #(.ACC_WIDTH(12), .COUNT_WIDTH(10)) dut2 (
    .clk(clk), .rst(rst), .i_done(done2), .i_accumulator(acc2), .i_inst_count(cnt2),
    .i_tx_done(tx_done2), .o_tx_start(start2), .o_tx_data(data2), .o_busy(busy2),
    .o_frame_done(fdone2), .o_overrun(ovr2));

  // UART model: record each launched byte and answer with i_tx_done 10 cycles later.
  initial begin
    tx_done1 = 1'b0;
    tx_done2 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_done1 = 1'b0;
      tx_done2 = 1'b0;
      if (cd1 > 0) begin cd1--; if (cd1 == 0) tx_done1 = 1'b1; end
      if (cd2 > 0) begin cd2--; if (cd2 == 0) tx_done2 = 1'b1; end
      if (start1) begin q1.push_back(data1); cd1 = 10; end
      if (start2) begin q2.push_back(data2); cd2 = 10; end
      if (fdone1) frames1++;
      if (fdone2) frames2++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_frame(input string tag, input byteq_t got, input byteq_t exp);
    check({tag, "_len"}, got.size(), exp.size());
    foreach (exp[i])
      check($sformatf("%s_b%0d", tag, i), (i < got.size()) ? 64'(got[i]) : 64'h1FF, exp[i]);
  endtask

  task automatic wait_frames1(input int target, input int budget);
    for (int i = 0; i < budget && frames1 < target; i++) tick();
    check("frames1_reached", frames1, target);
  endtask

  task automatic wait_frames2(input int target, input int budget);
    for (int i = 0; i < budget && frames2 < target; i++) tick();
    check("frames2_reached", frames2, target);
  endtask

  task automatic wait_q1(input int n, input int budget);
    for (int i = 0; i < budget && q1.size() < n; i++) tick();
    check("q1_bytes_reached", q1.size() >= n, 1);
  endtask

  byteq_t exp_a, exp_b, exp_c, exp_d;

  initial begin
    rst = 1'b1;
    done1 = 1'b0; acc1 = '0; cnt1 = '0;
    done2 = 1'b0; acc2 = '0; cnt2 = '0;

    exp_a = '{8'hA5, 8'h2A, 8'h12, 8'h34};
    exp_b = '{8'hA5, 8'h03, 8'hFF, 8'h0A, 8'hBC};
    exp_c = '{8'hA5, 8'h2A, 8'hFF, 8'hFF};
    exp_d = '{8'hA5, 8'h5A, 8'hC3, 8'hE1};
`ifdef BIP_REPORT_CHECKSUM_EN
    exp_a.push_back(8'h0C);
    exp_b.push_back(8'h4A);
    exp_c.push_back(8'h2A);
    exp_d.push_back(8'h78);
`endif

    #1;
    check("rst_tx_start", start1, 1'b0);
    check("rst_tx_data", data1, 8'h00);
    check("rst_busy", busy1, 1'b0);
    check("rst_frame_done", fdone1, 1'b0);
    check("rst_overrun", ovr1, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Default frame with first-byte latency
    cnt1 = 8'h2A; acc1 = 16'h1234; done1 = 1'b1;
    tick();
    check("lat_tx_start", start1, 1'b1);
    check("lat_tx_data", data1, 8'hA5);
    check("lat_busy", busy1, 1'b1);
    tick();
    done1 = 1'b0;
    wait_frames1(1, 300);
    check_frame("frameA", q1, exp_a);
    repeat (30) tick();
    check("frameA_single_done", frames1, 1);
    check("frameA_busy_low", busy1, 1'b0);
    check("frameA_no_overrun", ovr1, 1'b0);

    // Odd widths: zero-extended top bytes
    cnt2 = 10'h3FF; acc2 = 12'hABC; done2 = 1'b1;
    tick();
    done2 = 1'b0;
    wait_frames2(1, 300);
    check_frame("frameB", q2, exp_b);

    // Level held high, input change after capture, then re-arm
    q1.delete();
    done1 = 1'b1;
    tick(); tick();
    acc1 = 16'hFFFF;
    repeat (497) tick();
    check("held_one_frame", frames1, 2);
    done1 = 1'b0;
    tick(); tick();
    done1 = 1'b1;
    wait_frames1(3, 300);
    check_frame("held_frames", q1, {exp_a, exp_c});
    check("held_no_overrun", ovr1, 1'b0);

    // Second edge during byte 2
    done1 = 1'b0;
    q1.delete();
    tick();
    cnt1 = 8'h5A; acc1 = 16'hC3E1; done1 = 1'b1;
    tick();
    wait_q1(2, 200);
    tick();
    done1 = 1'b0;
    tick();
    done1 = 1'b1;
    tick(); tick();
    check("ovr_set", ovr1, 1'b1);
    wait_frames1(4, 300);
    repeat (100) tick();
    check("ovr_single_frame", frames1, 4);
    check("ovr_sticky", ovr1, 1'b1);
    check("ovr_busy_low", busy1, 1'b0);
    check_frame("ovr_frame", q1, exp_d);
    done1 = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("ovr_cleared_by_rst", ovr1, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Reset during WAIT of the first byte
    q1.delete();
    cnt1 = 8'h2A; acc1 = 16'h1234; done1 = 1'b1;
    tick();
    done1 = 1'b0;
    wait_q1(1, 50);
    tick(); tick(); tick();
    #3;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy1, 1'b0);
    check("midrst_tx_start", start1, 1'b0);
    check("midrst_tx_data", data1, 8'h00);
    check("midrst_frame_done", fdone1, 1'b0);
    tick(); tick();
    rst = 1'b0;
    repeat (40) tick();
    check("midrst_no_more_start", q1.size(), 1);
    check("midrst_no_frame_done", frames1, 4);
    q1.delete();
    done1 = 1'b1;
    tick();
    done1 = 1'b0;
    wait_frames1(5, 300);
    check_frame("post_rst", q1, exp_a);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bip_report_tx.md
Name: bip_report_tx

Overview:
- Parametrised result-reporting serialiser for the BIP core.
- On a rising edge of the processor's done signal it latches the instruction count and accumulator. It then emits them as a framed byte stream to an external UART TX through a start/done handshake.
- Generalises the fixed 16-bit accumulator / 8-bit count reporter. Adds:
  - arbitrary field widths
  - a header byte
  - edge-triggered re-arming
  - overrun detection
  - an optional checksum byte

Parameters:
- ACC_WIDTH, 16: accumulator width in bits (1..64); sent as N_ACC = ceil(ACC_WIDTH/8) bytes.
- COUNT_WIDTH, 8: instruction-count width in bits (1..32); sent as N_CNT = ceil(COUNT_WIDTH/8) bytes.
- HEADER_BYTE, 8'hA5: first byte of every frame.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- i_done  in  1  BIP done level; a frame starts on its 0->1 transition
- i_accumulator  in  ACC_WIDTH  accumulator value, sampled at trigger
- i_inst_count  in  COUNT_WIDTH  instruction count, sampled at trigger
- i_tx_done  in  1  one-cycle pulse from UART TX: current byte fully sent
- o_tx_start  out  1  one-cycle pulse: launch o_tx_data
- o_tx_data  out  8  byte to transmit, valid while o_tx_start=1
- o_busy  out  1  high from trigger capture until frame complete
- o_frame_done  out  1  one-cycle pulse after last byte's i_tx_done
- o_overrun  out  1  sticky: trigger edge seen while busy

Behaviour:
- Reset (async, rst=1): state=IDLE, all outputs 0, latches 0, done-edge register 0, byte index 0. Reset mid-frame abandons the frame immediately; no further o_tx_start.
- Edge detect: trig = i_done & ~done_q, where done_q is i_done registered every cycle. A level held high produces exactly one frame.
- Frame byte order:
  - HEADER_BYTE
  - count bytes, MSB first
  - accumulator bytes, MSB first
  - checksum byte (if enabled)
  - Fields are zero-extended to a whole number of bytes; the top byte carries the unused upper bits as 0.
- FSM:
  - IDLE: on trig, latch i_inst_count and i_accumulator into frame registers, byte index=0, o_busy=1 → SEND.
  - SEND: one cycle, o_tx_start=1, o_tx_data=byte[index] (registered outputs) → WAIT.
  - WAIT: o_tx_start=0. On i_tx_done:
    - if index = last → DONE
    - else index+1 → SEND
  - DONE: o_frame_done=1 for one cycle, o_busy=0 → IDLE.
- Latency:
  - o_tx_start rises the cycle after the capture edge.
  - Each subsequent byte's o_tx_start is asserted the cycle after the i_tx_done that ended the previous byte.
- i_tx_done handling: ignored in IDLE, SEND and DONE. A pulse coincident with o_tx_start does not advance the index.
- Input stability: the latched values are used for the whole frame. Input changes after capture do not affect bytes sent.
- Trig while o_busy=1 or in DONE:
  - ignored for framing;
  - o_overrun set to 1 and held until rst.
- Trig in the same cycle DONE returns to IDLE is not captured; it counts as overrun.
- o_tx_data holds its last value between bytes; it is only qualified by o_tx_start.
- Total bytes per frame: 1 + N_CNT + N_ACC (+1 with checksum). The byte index counter is sized to hold this count.

Optional Feature:
- Macro: BIP_REPORT_CHECKSUM_EN.
- Defined:
  - a final checksum byte is appended;
  - checksum = XOR of all count and accumulator bytes (header excluded), computed from the latched values;
  - o_frame_done follows the checksum byte's i_tx_done.
- Undefined: no checksum byte; the frame ends after the last accumulator byte. No checksum logic is synthesised.

Test Plan:
- Defaults, no checksum: inst_count=8'h2A, acc=16'h1234, pulse i_done, answer each o_tx_start with i_tx_done 10 cycles later → bytes A5, 2A, 12, 34; o_frame_done once; o_busy low afterwards.
- Same stimulus with BIP_REPORT_CHECKSUM_EN → bytes A5, 2A, 12, 34, 0C.
- ACC_WIDTH=12, COUNT_WIDTH=10, acc=12'hABC, count=10'h3FF → bytes A5, 03, FF, 0A, BC.
- i_done held high 500 cycles, then low, then high again → exactly two frames, o_overrun=0. Change i_accumulator after capture → transmitted bytes unchanged.
- Second i_done edge during byte 2 → single frame only; o_overrun=1 until rst.
- Assert rst during WAIT of byte 1 → all outputs 0 asynchronously, no further o_tx_start. After release, a new i_done edge yields a complete frame.
